// File: rtl/ctrl_seq.sv
// ctrl_seq: registered multi-cycle control sequencer (decode, load wait, halt, retire count).
// Optional define CTRL_ILLEGAL_TRAP_EN: undefined opcodes trap to HALTED and set Illegal.
module ctrl_seq #(
  parameter int MCODEBITS = 9,
  parameter int OPWIDTH   = 3,
  parameter int LOAD_WAIT = 2,
  parameter int CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [MCODEBITS-1:0] Instr,
  input  logic                 InstrValid,
  output logic                 Ready,
  output logic                 CtrlValid,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH:0]     ALUOp,
  output logic [1:0]           RegDst,
  output logic                 Halt,
  output logic                 Illegal,
  output logic [CNTW-1:0]      RetiredCnt
);

  localparam int AW = OPWIDTH + 1;
  localparam logic [AW-1:0] ALU_DEF = AW'(4'b0111);
  localparam logic [3:0] LW = 4'(LOAD_WAIT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic ready_q, ready_d;
  logic cv_q, cv_d;
  logic br_q, br_d;
  logic mtr_q, mtr_d;
  logic mw_q, mw_d;
  logic src_q, src_d;
  logic rw_q, rw_d;
  logic [AW-1:0] alu_q, alu_d;
  logic [1:0] dst_q, dst_d;
  logic halt_q, halt_d;
  logic illegal_q, illegal_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [3:0] op;
  logic dec_rw, dec_br, dec_mtr, dec_mw, dec_src;
  logic [AW-1:0] dec_alu;
  logic [1:0] dec_dst;
  logic dec_load, dec_halt, dec_undef;

  assign op = Instr[MCODEBITS-1 -: 4];

  if (MCODEBITS > 4) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^Instr[MCODEBITS-5:0];
  end

  // Opcode to datapath strobes; unlisted fields keep defaults.
  always_comb begin
    dec_rw    = 1'b1;
    dec_br    = 1'b0;
    dec_mtr   = 1'b0;
    dec_mw    = 1'b0;
    dec_src   = 1'b0;
    dec_alu   = ALU_DEF;
    dec_dst   = 2'd0;
    dec_load  = 1'b0;
    dec_halt  = 1'b0;
    dec_undef = 1'b0;
    case (op)
      4'b0000: begin
        dec_mtr  = 1'b1;
        dec_dst  = 2'd1;
        dec_load = 1'b1;
      end
      4'b0001: begin
        dec_rw = 1'b0;
        dec_mw = 1'b1;
      end
      4'b0010: dec_alu = AW'(4'b0001);
      4'b0011: begin
        dec_alu = AW'(4'b0010);
        dec_br  = 1'b1;
        dec_rw  = 1'b0;
      end
      4'b0100: dec_alu = AW'(4'b0011);
      4'b0101: begin
        dec_alu = AW'(4'b0110);
        dec_dst = 2'd2;
      end
      4'b0110: begin
        dec_alu = AW'(4'b0100);
        dec_src = 1'b1;
        dec_dst = 2'd1;
      end
      4'b0111: begin
        dec_alu = AW'(4'b0101);
        dec_src = 1'b1;
        dec_dst = 2'd1;
      end
      4'b1000: begin
        dec_src = 1'b1;
        dec_dst = 2'd1;
      end
      4'b1001: begin
        dec_alu = AW'(4'b1000);
        dec_dst = 2'd2;
      end
      4'b1010: dec_halt = 1'b1;
      4'b1011: dec_alu = AW'(4'b1010);
      4'b1100: dec_alu = AW'(4'b1011);
      4'b1101: begin
        dec_alu = AW'(4'b0100);
        dec_dst = 2'd1;
      end
      default: begin
        dec_rw    = 1'b0;
        dec_undef = 1'b1;
      end
    endcase
  end

  // Next state: accept in RUN, hold load controls through the wait, park in HALTED.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    cv_d      = 1'b0;
    br_d      = 1'b0;
    mtr_d     = 1'b0;
    mw_d      = 1'b0;
    src_d     = 1'b0;
    rw_d      = 1'b0;
    alu_d     = ALU_DEF;
    dst_d     = 2'd0;
    cnt_d     = cnt_q;
    if (cv_q && (wait_q == 4'd0) && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    case (state_q)
      RUN: begin
        if (InstrValid) begin
          if (dec_halt || (TRAP && dec_undef)) begin
            state_d   = HALTED;
            halt_d    = 1'b1;
            illegal_d = illegal_q | dec_undef;
          end else begin
            cv_d  = 1'b1;
            br_d  = dec_br;
            mtr_d = dec_mtr;
            mw_d  = dec_mw;
            src_d = dec_src;
            rw_d  = dec_rw;
            alu_d = dec_alu;
            dst_d = dec_dst;
            if (dec_load) begin
              wait_d = LW;
              if (LW != 4'd0) begin
                state_d = MEMWAIT;
                rw_d    = 1'b0;
              end
            end
          end
        end
      end
      MEMWAIT: begin
        cv_d   = cv_q;
        br_d   = br_q;
        mtr_d  = mtr_q;
        mw_d   = mw_q;
        src_d  = src_q;
        alu_d  = alu_q;
        dst_d  = dst_q;
        wait_d = wait_q - 4'd1;
        rw_d   = (wait_q == 4'd1);
        if (wait_q == 4'd1) begin
          state_d = RUN;
        end
      end
      HALTED: begin
      end
      default: state_d = RUN;
    endcase
    ready_d = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= RUN;
      wait_q    <= 4'd0;
      ready_q   <= 1'b1;
      cv_q      <= 1'b0;
      br_q      <= 1'b0;
      mtr_q     <= 1'b0;
      mw_q      <= 1'b0;
      src_q     <= 1'b0;
      rw_q      <= 1'b0;
      alu_q     <= ALU_DEF;
      dst_q     <= 2'd0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ready_q   <= ready_d;
      cv_q      <= cv_d;
      br_q      <= br_d;
      mtr_q     <= mtr_d;
      mw_q      <= mw_d;
      src_q     <= src_d;
      rw_q      <= rw_d;
      alu_q     <= alu_d;
      dst_q     <= dst_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Ready      = ready_q;
  assign CtrlValid  = cv_q;
  assign Branch     = br_q;
  assign MemtoReg   = mtr_q;
  assign MemWrite   = mw_q;
  assign ALUSrc     = src_q;
  assign RegWrite   = rw_q;
  assign ALUOp      = alu_q;
  assign RegDst     = dst_q;
  assign Halt       = halt_q;
  assign Illegal    = illegal_q;
  assign RetiredCnt = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed stimulus for ctrl_seq, checked against a cycle-level
// model of the instruction lifetime plus hand-computed literal expectations.
module tb_ctrl_seq;

  localparam int LW = 2;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [8:0] Instr = '0;
  logic       InstrValid = 1'b0;

  logic        Ready, CtrlValid, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [3:0]  ALUOp;
  logic [1:0]  RegDst;
  logic        Halt, Illegal;
  logic [15:0] RetiredCnt;

  logic        s_ready, s_cv, s_br, s_mtr, s_mw, s_src, s_rw;
  logic [3:0]  s_alu;
  logic [1:0]  s_dst;
  logic        s_halt, s_ill;
  logic [3:0]  s_cnt;

  ctrl_seq #(.MCODEBITS(9), .OPWIDTH(3), .LOAD_WAIT(LW), .CNTW(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .InstrValid(InstrValid),
    .Ready(Ready), .CtrlValid(CtrlValid), .Branch(Branch),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .RegDst(RegDst), .Halt(Halt),
    .Illegal(Illegal), .RetiredCnt(RetiredCnt)
  );

  ctrl_seq #(.MCODEBITS(9), .OPWIDTH(3), .LOAD_WAIT(LW), .CNTW(4)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .InstrValid(InstrValid),
    .Ready(s_ready), .CtrlValid(s_cv), .Branch(s_br),
    .MemtoReg(s_mtr), .MemWrite(s_mw), .ALUSrc(s_src),
    .RegWrite(s_rw), .ALUOp(s_alu), .RegDst(s_dst), .Halt(s_halt),
    .Illegal(s_ill), .RetiredCnt(s_cnt)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected fields {rw,br,mtr,mw,src,alu[3:0],dst[1:0]} per opcode.
  function automatic logic [10:0] fields(input int op);
    case (op)
      0:       return 11'b1_0_1_0_0_0111_01;
      1:       return 11'b0_0_0_1_0_0111_00;
      2:       return 11'b1_0_0_0_0_0001_00;
      3:       return 11'b0_1_0_0_0_0010_00;
      4:       return 11'b1_0_0_0_0_0011_00;
      5:       return 11'b1_0_0_0_0_0110_10;
      6:       return 11'b1_0_0_0_1_0100_01;
      7:       return 11'b1_0_0_0_1_0101_01;
      8:       return 11'b1_0_0_0_1_0111_01;
      9:       return 11'b1_0_0_0_0_1000_10;
      11:      return 11'b1_0_0_0_0_1010_00;
      12:      return 11'b1_0_0_0_0_1011_00;
      13:      return 11'b1_0_0_0_0_0100_01;
      default: return 11'b0_0_0_0_0_0111_00;
    endcase
  endfunction

  // Model: the live instruction and how many control cycles it still owns.
  bit m_live, m_halt, m_ill;
  int m_rem, m_cnt, m_op;

  always @(posedge Clk or negedge Reset_n) begin : model
    bit live, halt, ill, rdy;
    int rem, cnt, op, o;
    if (!Reset_n) begin
      m_live <= 1'b0;
      m_halt <= 1'b0;
      m_ill  <= 1'b0;
      m_rem  <= 0;
      m_cnt  <= 0;
      m_op   <= 0;
    end else begin
      live = m_live; halt = m_halt; ill = m_ill;
      rem = m_rem; cnt = m_cnt; op = m_op;
      rdy = !halt && (!live || rem == 1);
      if (live && rem == 1) cnt++;
      if (live) begin
        rem--;
        if (rem == 0) live = 1'b0;
      end
      if (rdy && InstrValid) begin
        o = int'(Instr[8:5]);
        if (o == 10 || (TRAP && o >= 14)) begin
          halt = 1'b1;
          if (o >= 14) ill = 1'b1;
        end else begin
          live = 1'b1;
          op   = o;
          rem  = (o == 0) ? LW + 1 : 1;
        end
      end
      m_live <= live; m_halt <= halt; m_ill <= ill;
      m_rem  <= rem;  m_cnt  <= cnt;  m_op  <= op;
    end
  end

  // Compare every cycle outside reset.
  always @(negedge Clk) begin : cmp
    logic [10:0] f;
    logic [14:0] e, a;
    if (Reset_n) begin
      f = m_live ? fields(m_op) : 11'b0_0_0_0_0_0111_00;
      e = {!m_halt && (!m_live || m_rem == 1), m_live, f[9], f[8], f[7],
           f[6], f[10] && m_live && m_rem == 1, f[5:2], f[1:0], m_halt, m_ill};
      a = {Ready, CtrlValid, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
           ALUOp, RegDst, Halt, Illegal};
      check("model_ctrl", 32'(a), 32'(e));
      check("model_cnt", 32'(RetiredCnt), (m_cnt > 65535) ? 65535 : m_cnt);
      check("model_sat", 32'(s_cnt), (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  // Present op with InstrValid high until an edge with Ready accepts it.
  task automatic issue(input logic [3:0] op);
    bit b;
    Instr = {op, 5'b0};
    InstrValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b = Ready;
      @(negedge Clk);
      if (b) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL issue_timeout: op %0h never accepted", op);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_ready", 32'(Ready), 1);
    check("rst_cv", 32'(CtrlValid), 0);
    check("rst_alu", 32'(ALUOp), 4'b0111);
    check("rst_cnt", 32'(RetiredCnt), 0);
    check("rst_halt", 32'(Halt), 0);
    Reset_n = 1'b1;

    // single add
    @(negedge Clk);
    Instr = 9'b0100_00000;
    InstrValid = 1'b1;
    @(negedge Clk);
    InstrValid = 1'b0;
    check("add_cv", 32'(CtrlValid), 1);
    check("add_rw", 32'(RegWrite), 1);
    check("add_alu", 32'(ALUOp), 4'b0011);
    @(negedge Clk);
    check("add_cv_off", 32'(CtrlValid), 0);
    check("add_cnt", 32'(RetiredCnt), 1);

    // load with valid held, add follows
    Instr = 9'b0000_00000;
    InstrValid = 1'b1;
    @(negedge Clk);
    Instr = 9'b0100_00000;
    check("ld1_rdy", 32'(Ready), 0);
    check("ld1_mtr", 32'(MemtoReg), 1);
    check("ld1_rw", 32'(RegWrite), 0);
    @(negedge Clk);
    check("ld2_rdy", 32'(Ready), 0);
    check("ld2_mtr", 32'(MemtoReg), 1);
    check("ld2_rw", 32'(RegWrite), 0);
    @(negedge Clk);
    check("ld3_rdy", 32'(Ready), 1);
    check("ld3_mtr", 32'(MemtoReg), 1);
    check("ld3_rw", 32'(RegWrite), 1);
    @(negedge Clk);
    InstrValid = 1'b0;
    check("ldadd_alu", 32'(ALUOp), 4'b0011);
    check("ldadd_mtr", 32'(MemtoReg), 0);
    check("ldadd_cnt", 32'(RetiredCnt), 2);
    @(negedge Clk);
    check("ldadd_cnt2", 32'(RetiredCnt), 3);

    // opcode sweep, back to back
    begin
      automatic int ops[13] = '{1, 2, 3, 5, 6, 7, 8, 9, 11, 12, 13, 0, 4};
      foreach (ops[i]) issue(4'(ops[i]));
    end
    InstrValid = 1'b0;
    repeat (3) @(negedge Clk);
    check("sweep_cnt", 32'(RetiredCnt), 16);

    // undefined opcode
    issue(4'b1111);
    InstrValid = 1'b0;
    check("u_ill", 32'(Illegal), 32'(TRAP));
    check("u_halt", 32'(Halt), 32'(TRAP));
    check("u_cv", 32'(CtrlValid), 32'(!TRAP));
    check("u_rw", 32'(RegWrite), 0);
    @(negedge Clk);
    check("u_cnt", 32'(RetiredCnt), TRAP ? 16 : 17);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;

    // halt then store held valid
    issue(4'b1010);
    Instr = 9'b0001_00000;
    repeat (4) begin
      @(negedge Clk);
      check("h_halt", 32'(Halt), 1);
      check("h_rdy", 32'(Ready), 0);
      check("h_mw", 32'(MemWrite), 0);
      check("h_cnt", 32'(RetiredCnt), 0);
    end
    InstrValid = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("hr_halt", 32'(Halt), 0);
    check("hr_rdy", 32'(Ready), 1);
    @(negedge Clk);
    Reset_n = 1'b1;

    // reset mid-clock in the second load wait cycle
    issue(4'b0000);
    InstrValid = 1'b0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mr_cv", 32'(CtrlValid), 0);
    check("mr_mtr", 32'(MemtoReg), 0);
    check("mr_rw", 32'(RegWrite), 0);
    check("mr_rdy", 32'(Ready), 1);
    check("mr_alu", 32'(ALUOp), 4'b0111);
    @(posedge Clk);
    #1 check("mr_rw_edge", 32'(RegWrite), 0);
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("mr_norw", 32'(RegWrite), 0);
    end

    // 17 adds: 4-bit counter saturates
    Instr = 9'b0100_00000;
    InstrValid = 1'b1;
    repeat (17) @(negedge Clk);
    InstrValid = 1'b0;
    repeat (2) @(negedge Clk);
    check("sat_cnt", 32'(s_cnt), 15);
    check("full_cnt", 32'(RetiredCnt), 17);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
